// File: rtl/rs_status_array_if.sv
// Enqueue / issue / wakeup / dequeue-response bundle between the RS select
// policy and the per-entry status array.
interface rs_status_array_if #(
  parameter int NUM_ENTRY = 8,
  parameter int PTAG_W    = 6
);
  logic [NUM_ENTRY-1:0] io_validVec;
  logic [NUM_ENTRY-1:0] io_allocate;
  logic                 io_enq_valid;
  logic [PTAG_W-1:0]    io_enq_psrc_0;
  logic [PTAG_W-1:0]    io_enq_psrc_1;
  logic                 io_enq_srcReady_0;
  logic                 io_enq_srcReady_1;
  logic [NUM_ENTRY-1:0] io_request;
  logic                 io_grant_valid;
  logic [NUM_ENTRY-1:0] io_grant_bits;
  logic                 io_wakeup_valid_0;
  logic                 io_wakeup_valid_1;
  logic [PTAG_W-1:0]    io_wakeup_pdest_0;
  logic [PTAG_W-1:0]    io_wakeup_pdest_1;
  logic                 io_deqResp_valid;
  logic [NUM_ENTRY-1:0] io_deqResp_bits;
  logic                 io_deqResp_success;
  logic                 io_full;
  logic [3:0]           io_count;

  modport master (
    output io_allocate, io_enq_valid, io_enq_psrc_0, io_enq_psrc_1,
           io_enq_srcReady_0, io_enq_srcReady_1, io_grant_valid, io_grant_bits,
           io_wakeup_valid_0, io_wakeup_valid_1, io_wakeup_pdest_0, io_wakeup_pdest_1,
           io_deqResp_valid, io_deqResp_bits, io_deqResp_success,
    input  io_validVec, io_request, io_full, io_count
  );

  modport slave (
    input  io_allocate, io_enq_valid, io_enq_psrc_0, io_enq_psrc_1,
           io_enq_srcReady_0, io_enq_srcReady_1, io_grant_valid, io_grant_bits,
           io_wakeup_valid_0, io_wakeup_valid_1, io_wakeup_pdest_0, io_wakeup_pdest_1,
           io_deqResp_valid, io_deqResp_bits, io_deqResp_success,
    output io_validVec, io_request, io_full, io_count
  );
endinterface

// File: rtl/rs_status_array.sv
// Reservation-station status array: per-entry valid/scheduled/operand-ready
// state driving the allocate and issue select vectors.
module rs_status_entry #(
  parameter int NUM_SRC = 2,
  parameter int PTAG_W  = 6,
  parameter int NUM_WK  = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enq,
  input  logic [NUM_SRC-1:0][PTAG_W-1:0]   enq_psrc,
  input  logic [NUM_SRC-1:0]               enq_rdy,
  input  logic [NUM_WK-1:0]                wk_vld,
  input  logic [NUM_WK-1:0][PTAG_W-1:0]    wk_tag,
  input  logic                             grant,
  input  logic                             deq,
  input  logic                             deq_success,
  output logic                             valid,
  output logic                             request
);
  logic                           valid_q, valid_d;
  logic                           sched_q, sched_d;
  logic [NUM_SRC-1:0]             rdy_q, rdy_d;
  logic [NUM_SRC-1:0][PTAG_W-1:0] psrc_q, psrc_d;

  // Tag 0 is the hardwired "no register" tag and never wakes.
  function automatic logic woken(input logic [PTAG_W-1:0] tag,
                                 input logic [NUM_WK-1:0] vld,
                                 input logic [NUM_WK-1:0][PTAG_W-1:0] wtag);
    woken = 1'b0;
    for (int j = 0; j < NUM_WK; j++)
      if (vld[j] && wtag[j] == tag && tag != '0) woken = 1'b1;
  endfunction

  assign valid   = valid_q;
  assign request = valid_q & ~sched_q & (&rdy_q);

  always_comb begin
    valid_d = valid_q;
    sched_d = sched_q;
    rdy_d   = rdy_q;
    psrc_d  = psrc_q;
    if (valid_q) begin
      for (int k = 0; k < NUM_SRC; k++)
        if (woken(psrc_q[k], wk_vld, wk_tag)) rdy_d[k] = 1'b1;
      if (grant && request) sched_d = 1'b1;
      // Response overrides a same-cycle grant: replay must re-request.
      if (deq) begin
        sched_d = 1'b0;
        if (deq_success) valid_d = 1'b0;
      end
    end else if (enq) begin
      valid_d = 1'b1;
      sched_d = 1'b0;
      psrc_d  = enq_psrc;
      for (int k = 0; k < NUM_SRC; k++)
        rdy_d[k] = enq_rdy[k] | woken(enq_psrc[k], wk_vld, wk_tag);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      sched_q <= 1'b0;
      rdy_q   <= '0;
      psrc_q  <= '0;
    end else begin
      valid_q <= valid_d;
      sched_q <= sched_d;
      rdy_q   <= rdy_d;
      psrc_q  <= psrc_d;
    end
  end
endmodule

module rs_status_array #(
  parameter int NUM_ENTRY = 8,
  parameter int NUM_SRC   = 2,
  parameter int PTAG_W    = 6
) (
  input  logic               clock,
  input  logic               reset,
  rs_status_array_if.slave   io
);
  localparam int NUM_WK = 2;

  logic [NUM_SRC-1:0][PTAG_W-1:0] enq_psrc;
  logic [NUM_SRC-1:0]             enq_rdy;
  logic [NUM_WK-1:0]              wk_vld;
  logic [NUM_WK-1:0][PTAG_W-1:0]  wk_tag;
  logic [NUM_ENTRY-1:0]           valid;
  logic [NUM_ENTRY-1:0]           request;
  logic [3:0]                     cnt;

  assign enq_psrc[0] = io.io_enq_psrc_0;
  assign enq_psrc[1] = io.io_enq_psrc_1;
  assign enq_rdy     = {io.io_enq_srcReady_1, io.io_enq_srcReady_0};
  assign wk_vld      = {io.io_wakeup_valid_1, io.io_wakeup_valid_0};
  assign wk_tag[0]   = io.io_wakeup_pdest_0;
  assign wk_tag[1]   = io.io_wakeup_pdest_1;

  for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_ent
    rs_status_entry #(.NUM_SRC(NUM_SRC), .PTAG_W(PTAG_W), .NUM_WK(NUM_WK)) u_ent (
      .clock       (clock),
      .reset       (reset),
      .enq         (io.io_enq_valid & io.io_allocate[i]),
      .enq_psrc    (enq_psrc),
      .enq_rdy     (enq_rdy),
      .wk_vld      (wk_vld),
      .wk_tag      (wk_tag),
      .grant       (io.io_grant_valid & io.io_grant_bits[i]),
      .deq         (io.io_deqResp_valid & io.io_deqResp_bits[i]),
      .deq_success (io.io_deqResp_success),
      .valid       (valid[i]),
      .request     (request[i])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_ENTRY; i++) cnt = cnt + 4'(valid[i]);
  end

  assign io.io_validVec = valid;
  assign io.io_request  = request;
  assign io.io_count    = cnt;
  assign io.io_full     = &valid;
endmodule

// File: tb/tb_rs_status_array.sv
// Scenario bench for rs_status_array: expectations are queued as stimulus is
// driven and checked against the registered state one cycle later.
module tb_rs_status_array;
  logic clock;
  logic reset;

  rs_status_array_if bus ();

  rs_status_array dut (.clock(clock), .reset(reset), .io(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] vv;
    logic [7:0] rq;
    logic [3:0] cnt;
    logic       full;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always @(posedge clock) begin
    if (reset && bus.io_enq_valid)
      assert ($onehot0(bus.io_allocate)) else $error("allocate not one-hot: %b", bus.io_allocate);
    if (reset && bus.io_grant_valid)
      assert ($onehot0(bus.io_grant_bits)) else $error("grant not one-hot: %b", bus.io_grant_bits);
    if (reset && bus.io_deqResp_valid)
      assert ($onehot0(bus.io_deqResp_bits)) else $error("deqResp not one-hot: %b", bus.io_deqResp_bits);
  end

  task automatic clr();
    bus.io_allocate        = '0;
    bus.io_enq_valid       = 1'b0;
    bus.io_enq_psrc_0      = '0;
    bus.io_enq_psrc_1      = '0;
    bus.io_enq_srcReady_0  = 1'b0;
    bus.io_enq_srcReady_1  = 1'b0;
    bus.io_grant_valid     = 1'b0;
    bus.io_grant_bits      = '0;
    bus.io_wakeup_valid_0  = 1'b0;
    bus.io_wakeup_valid_1  = 1'b0;
    bus.io_wakeup_pdest_0  = '0;
    bus.io_wakeup_pdest_1  = '0;
    bus.io_deqResp_valid   = 1'b0;
    bus.io_deqResp_bits    = '0;
    bus.io_deqResp_success = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input int idx, input logic [5:0] p0, input logic [5:0] p1,
                     input logic r0, input logic r1);
    bus.io_enq_valid      = 1'b1;
    bus.io_allocate       = '0;
    bus.io_allocate[idx]  = 1'b1;
    bus.io_enq_psrc_0     = p0;
    bus.io_enq_psrc_1     = p1;
    bus.io_enq_srcReady_0 = r0;
    bus.io_enq_srcReady_1 = r1;
  endtask

  task automatic wake(input int port, input logic [5:0] tag);
    if (port == 0) begin
      bus.io_wakeup_valid_0 = 1'b1;
      bus.io_wakeup_pdest_0 = tag;
    end else begin
      bus.io_wakeup_valid_1 = 1'b1;
      bus.io_wakeup_pdest_1 = tag;
    end
  endtask

  task automatic grant(input int idx);
    bus.io_grant_valid     = 1'b1;
    bus.io_grant_bits      = '0;
    bus.io_grant_bits[idx] = 1'b1;
  endtask

  task automatic deq(input int idx, input logic ok);
    bus.io_deqResp_valid     = 1'b1;
    bus.io_deqResp_bits      = '0;
    bus.io_deqResp_bits[idx] = 1'b1;
    bus.io_deqResp_success   = ok;
  endtask

  task automatic push(input string n, input logic [7:0] vv, input logic [7:0] rq,
                      input logic [3:0] c, input logic f);
    exp_t e;
    e.name = n; e.vv = vv; e.rq = rq; e.cnt = c; e.full = f;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    clr();
    reset = 1'b0;
    #2;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      clr();
      if (s == 0) begin
        reset = 1'b0;
        #3;
        push("reset_hold", 8'h00, 8'h00, 4'd0, 1'b0);
      end else begin
        @(negedge clock);
        reset = 1'b1;
        push("reset_release", 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
      end
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_enq_ready();
    exp_t e;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      clr();
      case (s)
        0: begin enq(0, 6'd1, 6'd2, 1'b1, 1'b1); push("enq_ready",   8'h01, 8'h01, 4'd1, 1'b0); end
        1: begin grant(0);                       push("grant_drop",  8'h01, 8'h00, 4'd1, 1'b0); end
        default: begin deq(0, 1'b1);             push("deq_success", 8'h00, 8'h00, 4'd0, 1'b0); end
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_wakeup();
    exp_t e;
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      clr();
      case (s)
        0: begin enq(2, 6'd5, 6'd7, 1'b0, 1'b1); push("wk_enq_notready", 8'h04, 8'h00, 4'd1, 1'b0); end
        1: begin wake(0, 6'd9);                  push("wk_wrong_tag",    8'h04, 8'h00, 4'd1, 1'b0); end
        2: begin wake(1, 6'd5);                  push("wk_port1_match",  8'h04, 8'h04, 4'd1, 1'b0); end
        3: begin deq(2, 1'b1);                   push("wk_free",         8'h00, 8'h00, 4'd0, 1'b0); end
        default: begin
          enq(2, 6'd5, 6'd3, 1'b0, 1'b1);
          wake(0, 6'd5);
          push("wk_same_cycle_enq", 8'h04, 8'h04, 4'd1, 1'b0);
        end
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_replay();
    exp_t e;
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      clr();
      case (s)
        0: begin enq(3, 6'd1, 6'd2, 1'b1, 1'b1);  push("rp_enq",          8'h08, 8'h08, 4'd1, 1'b0); end
        1: begin grant(3);                        push("rp_grant",        8'h08, 8'h00, 4'd1, 1'b0); end
        2: begin deq(3, 1'b0);                    push("rp_reject",       8'h08, 8'h08, 4'd1, 1'b0); end
        3: begin grant(3); deq(3, 1'b0);          push("rp_deq_beats_gnt",8'h08, 8'h08, 4'd1, 1'b0); end
        4: begin grant(3);                        push("rp_regrant",      8'h08, 8'h00, 4'd1, 1'b0); end
        default: begin deq(3, 1'b1);              push("rp_retire",       8'h00, 8'h00, 4'd0, 1'b0); end
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_full();
    exp_t e;
    apply_reset();
    for (int s = 0; s < 11; s++) begin
      clr();
      if (s < 8) begin
        enq(s, 6'(s + 1), 6'(s + 20), 1'b1, 1'b1);
        push("full_fill", 8'((1 << (s + 1)) - 1), 8'((1 << (s + 1)) - 1), 4'(s + 1), s == 7);
      end else if (s == 8) begin
        enq(4, 6'd9, 6'd10, 1'b0, 1'b0);
        push("full_enq_valid_ignored", 8'hFF, 8'hFF, 4'd8, 1'b1);
      end else if (s == 9) begin
        deq(6, 1'b1);
        push("full_free6", 8'hBF, 8'hBF, 4'd7, 1'b0);
      end else begin
        enq(6, 6'd11, 6'd12, 1'b1, 1'b1);
        push("full_refill6", 8'hFF, 8'hFF, 4'd8, 1'b1);
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_tag0();
    exp_t e;
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      clr();
      case (s)
        0: begin enq(1, 6'd0, 6'd0, 1'b0, 1'b1); wake(0, 6'd0); push("t0_enq_wake", 8'h02, 8'h00, 4'd1, 1'b0); end
        1: begin wake(0, 6'd0); wake(1, 6'd0);                  push("t0_wake",     8'h02, 8'h00, 4'd1, 1'b0); end
        2: begin deq(1, 1'b1);                                  push("t0_free",     8'h00, 8'h00, 4'd0, 1'b0); end
        default: begin enq(1, 6'd0, 6'd0, 1'b1, 1'b1);          push("t0_replaced", 8'h02, 8'h02, 4'd1, 1'b0); end
      endcase
      tick();
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      clr();
      enq(i, 6'(i + 1), 6'(i + 1), 1'b1, 1'b1);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin
        push("mid_before_reset", 8'h1F, 8'h1F, 4'd5, 1'b0);
      end else if (s == 1) begin
        clr();
        enq(5, 6'd1, 6'd1, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        push("mid_reset_immediate", 8'h00, 8'h00, 4'd0, 1'b0);
      end else begin
        @(negedge clock);
        clr();
        reset = 1'b1;
        push("mid_after_release", 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
      end
      e = sb.pop_front();
      total++;
      if ({bus.io_validVec, bus.io_request, bus.io_count, bus.io_full} !== {e.vv, e.rq, e.cnt, e.full})
        $display("FAIL %s: got vv=%h rq=%h cnt=%0d full=%b, want vv=%h rq=%h cnt=%0d full=%b",
                 e.name, bus.io_validVec, bus.io_request, bus.io_count, bus.io_full, e.vv, e.rq, e.cnt, e.full);
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    clr();
    test_reset();
    test_enq_ready();
    test_wakeup();
    test_replay();
    test_full();
    test_tag0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
